// File: rtl/bcd_sub_seq.sv
// Sequential 4-digit BCD subtractor: one shared digit stage walks the digits,
// then a second ten's-complement pass turns a borrowed result into |A-B|.
module bcd_sub_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] diff,
  output logic        neg,
  output logic        err
);

  typedef enum logic [3:0] {
    IDLE, SUB0, SUB1, SUB2, SUB3, COMP0, COMP1, COMP2, COMP3, DONE
  } state_t;

  state_t      state;
  logic [15:0] a_q, b_q, work;
  logic        borrow, err_q;

  logic [1:0]  idx;
  logic        in_comp;
  logic [3:0]  x, y;
  logic [4:0]  dres;
  logic [15:0] work_nx;

  // {bout, digit} for one BCD digit of x - y - bin
  function automatic logic [4:0] bcd_digit_sub(input logic [3:0] dx, input logic [3:0] dy,
                                               input logic bin);
    logic [4:0] raw;
    raw = {1'b0, dx} - {1'b0, dy} - {4'b0000, bin};
    if (raw[4]) bcd_digit_sub = {1'b1, raw[3:0] + 4'd10};
    else        bcd_digit_sub = {1'b0, raw[3:0]};
  endfunction

  function automatic logic has_non_bcd(input logic [15:0] v);
    has_non_bcd = (v[3:0] > 4'd9) || (v[7:4] > 4'd9) ||
                  (v[11:8] > 4'd9) || (v[15:12] > 4'd9);
  endfunction

  always_comb begin
    idx     = 2'd0;
    in_comp = 1'b0;
    case (state)
      SUB1:    idx = 2'd1;
      SUB2:    idx = 2'd2;
      SUB3:    idx = 2'd3;
      COMP0:   in_comp = 1'b1;
      COMP1:   begin idx = 2'd1; in_comp = 1'b1; end
      COMP2:   begin idx = 2'd2; in_comp = 1'b1; end
      COMP3:   begin idx = 2'd3; in_comp = 1'b1; end
      default: idx = 2'd0;
    endcase
    x       = in_comp ? 4'd0 : a_q[{idx, 2'b00} +: 4];
    y       = in_comp ? work[{idx, 2'b00} +: 4] : b_q[{idx, 2'b00} +: 4];
    dres    = bcd_digit_sub(x, y, borrow);
    work_nx = work;
    work_nx[{idx, 2'b00} +: 4] = dres[3:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= 16'h0000;
      b_q    <= 16'h0000;
      work   <= 16'h0000;
      borrow <= 1'b0;
      err_q  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= 16'h0000;
      neg    <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= 1'b0;
            err_q  <= has_non_bcd(a) | has_non_bcd(b);
            busy   <= 1'b1;
            state  <= SUB0;
          end
        end
        SUB0, SUB1, SUB2, COMP0, COMP1, COMP2: begin
          work   <= work_nx;
          borrow <= dres[4];
          state  <= state_t'(state + 4'd1);
        end
        SUB3: begin
          work   <= work_nx;
          borrow <= 1'b0;
          if (dres[4]) begin
            state <= COMP0;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= work_nx;
            neg   <= 1'b0;
            err   <= err_q;
          end
        end
        COMP3: begin
          work   <= work_nx;
          borrow <= dres[4];
          state  <= DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
          diff   <= work_nx;
          // a zero magnitude never reports as negative
          neg    <= (work_nx != 16'h0000);
          err    <= err_q;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bcd_sub_seq.md
BCD_SUB_SEQ -- requirements
Module: bcd_sub_seq

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: start  input  1  request a new subtraction; sampled only in IDLE.
REQ-004 SHALL have port: a  input  16  minuend, 4 BCD digits, digit 0 = a[3:0].
REQ-005 SHALL have port: b  input  16  subtrahend, 4 BCD digits, same packing as a.
REQ-006 SHALL have port: busy  output  1  high while in SUB0-SUB3 or COMP0-COMP3.
REQ-007 SHALL have port: done  output  1  one-cycle pulse; result outputs valid in that cycle.
REQ-008 SHALL have port: diff  output  16  magnitude |A-B|, 4 BCD digits.
REQ-009 SHALL have port: neg  output  1  high when A < B.
REQ-010 SHALL have port: err  output  1  high when any digit of the latched a or b is > 9.

Function
REQ-011 SHALL use a single 1-digit BCD subtract stage, time-shared across digits.
- raw5 = {0,x} - {0,y} - bin.
- If raw5[4] = 1: digit = raw5 + 10 (4 LSBs), bout = 1.
- Else: digit = raw5[3:0], bout = 0.
REQ-012 SHALL implement FSM states IDLE, SUB0, SUB1, SUB2, SUB3, COMP0, COMP1, COMP2, COMP3, DONE.
REQ-013 In IDLE with start = 1 at a clock edge, SHALL latch a and b, clear the borrow register, and go to SUB0.
- err SHALL be computed from the latched operands at this same edge.
REQ-014 In SUBi, SHALL compute latched A digit i minus latched B digit i minus the borrow register.
- Write the result into working digit i; store bout in the borrow register; advance to SUB(i+1).
REQ-015 On leaving SUB3:
- Final borrow = 0: go to DONE.
- Final borrow = 1: clear the borrow register and go to COMP0.
REQ-016 In COMPi, SHALL compute 0 minus working digit i minus the borrow register, writing back to digit i.
- This ten's-complement pass yields the magnitude.
- COMP3 goes to DONE.
REQ-017 In DONE, SHALL assert done = 1 and go to IDLE at the next edge. start SHALL be ignored in DONE.
REQ-018 Latency, with start sampled at the end of cycle N:
- done high in cycle N+5 when A >= B.
- done high in cycle N+9 when A < B.
- done SHALL be high for exactly one cycle.
REQ-019 diff, neg and err SHALL be registered and updated only on the edge entering DONE.
- They SHALL hold their values until the next DONE entry; intermediate working values SHALL never appear on the outputs.
REQ-020 neg SHALL equal the final SUB3 borrow, except that a zero result SHALL give neg = 0.
REQ-021 start SHALL be ignored in every state except IDLE. Operand changes after the start edge SHALL have no effect.
REQ-022 Non-BCD input digits SHALL still be processed with the REQ-011 arithmetic and SHALL set err. The result is then undefined but deterministic.
REQ-023 busy SHALL be low in IDLE and DONE. Maximum throughput is one operation per 6 cycles (A >= B) or 10 cycles (A < B).

Reset
REQ-024 When rst_n = 0 at a clock edge, SHALL enter IDLE and clear the borrow register, working digits, diff, neg, err, busy and done to 0.
REQ-025 Reset asserted in any state, including mid-SUB or mid-COMP, SHALL abort the operation with no done pulse.
- The first start after rst_n returns high SHALL be accepted normally.

Verification
REQ-026 a=0x4321, b=0x1234, start at cycle N -> done in cycle N+5, diff=0x3087, neg=0, err=0.
REQ-027 a=0x1234, b=0x4321 -> done in cycle N+9, diff=0x3087, neg=1; a=0x0000, b=0x0001 -> diff=0x0001, neg=1.
REQ-028 a=0x9999, b=0x9999 -> diff=0x0000, neg=0, done in cycle N+5; a=0x1000, b=0x0999 -> diff=0x0001, neg=0.
REQ-029 start pulsed again, with different operands, during SUB2 and during DONE -> ignored; the first result is unchanged, and exactly one done pulse occurs.
REQ-030 rst_n low for one cycle during COMP1 -> no done pulse and all outputs 0; the next start with a=0x0500, b=0x0250 -> diff=0x0250, neg=0.
REQ-031 a=0x00A0, b=0x0000 -> err=1 at done; a subsequent valid operation -> err=0.
